// File: rtl/saed32_dpram_init.sv
// saed32_dpram_init: parametrised dual-port synchronous RAM with per-bit write
// masks, optional output register, port-collision merge and a post-reset
// sequencer that fills every word with INIT_VAL.
module saed32_dpram_init #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 64,
    parameter int unsigned      ADDR_W   = 6,
    parameter int unsigned      OUT_REG  = 0,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] A0,
    input  logic [ADDR_W-1:0] A1,
    input  logic [WIDTH-1:0]  D0,
    input  logic [WIDTH-1:0]  D1,
    input  logic [WIDTH-1:0]  WEM0,
    input  logic [WIDTH-1:0]  WEM1,
    input  logic              CE0,
    input  logic              CE1,
    input  logic              WE0,
    input  logic              WE1,
    output logic [WIDTH-1:0]  Q0,
    output logic [WIDTH-1:0]  Q1,
    output logic              INIT_DONE,
    output logic              DROP0,
    output logic              DROP1
);

    localparam int unsigned       IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t               state;
    logic [ADDR_W-1:0]    cnt;
    logic [WIDTH-1:0]     mem [0:DEPTH-1];

    logic                 ready;
    logic                 in0;
    logic                 in1;
    logic                 rd0;
    logic                 rd1;
    logic                 wr0;
    logic                 wr1;
    logic                 same;
    logic [IDX_W-1:0]     idx0;
    logic [IDX_W-1:0]     idx1;
    logic [IDX_W-1:0]     init_idx;
    logic [WIDTH-1:0]     rdata0;
    logic [WIDTH-1:0]     rdata1;
    logic [WIDTH-1:0]     wdata0;
    logic [WIDTH-1:0]     wdata1;
    logic [WIDTH-1:0]     wmerge;

    assign ready    = (state == ST_READY);
    assign in0      = ({1'b0, A0} < DEPTH_A);
    assign in1      = ({1'b0, A1} < DEPTH_A);
    assign idx0     = IDX_W'(A0);
    assign idx1     = IDX_W'(A1);
    assign init_idx = IDX_W'(cnt);

    assign rd0  = ready && CE0 && !WE0 && in0;
    assign rd1  = ready && CE1 && !WE1 && in1;
    assign wr0  = ready && CE0 && WE0 && in0;
    assign wr1  = ready && CE1 && WE1 && in1;
    assign same = wr0 && wr1 && (A0 == A1);

    // Read-first: reads and merge inputs see the pre-edge array contents.
    assign rdata0 = mem[idx0];
    assign rdata1 = mem[idx1];
    assign wdata0 = (rdata0 & ~WEM0) | (D0 & WEM0);
    assign wdata1 = (rdata1 & ~WEM1) | (D1 & WEM1);
    // Same-address double write: port 0 owns its masked bits, port 1 fills the rest.
    assign wmerge = (rdata0 & ~(WEM0 | WEM1)) | (D0 & WEM0) | (D1 & WEM1 & ~WEM0);

    // Array update: init fill while sequencing, masked port writes when ready.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (!ready) begin
                mem[init_idx] <= INIT_VAL;
            end else if (same) begin
                mem[idx0] <= wmerge;
            end else begin
                if (wr0) mem[idx0] <= wdata0;
                if (wr1) mem[idx1] <= wdata1;
            end
        end
    end

    // Init sequencer FSM plus registered done/drop flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_INIT;
            cnt       <= '0;
            INIT_DONE <= 1'b0;
            DROP0     <= 1'b0;
            DROP1     <= 1'b0;
        end else begin
            DROP0 <= CE0 && (!ready || !in0);
            DROP1 <= CE1 && (!ready || !in1);
            case (state)
                ST_INIT: begin
                    if (cnt == LAST) begin
                        state     <= ST_READY;
                        INIT_DONE <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= ST_READY;
                end
            endcase
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [WIDTH-1:0] pipe0;
        logic [WIDTH-1:0] pipe1;
        logic             pv0;
        logic             pv1;

        // Two-stage read path; Q only moves when a read reaches the last stage.
        always_ff @(posedge CLK) begin
            if (RST) begin
                pipe0 <= '0;
                pipe1 <= '0;
                pv0   <= 1'b0;
                pv1   <= 1'b0;
                Q0    <= '0;
                Q1    <= '0;
            end else begin
                pv0 <= rd0;
                pv1 <= rd1;
                if (rd0) pipe0 <= rdata0;
                if (rd1) pipe1 <= rdata1;
                if (pv0) Q0 <= pipe0;
                if (pv1) Q1 <= pipe1;
            end
        end
    end else begin : g_direct
        // Single-stage read path; Q holds on idle, write and dropped cycles.
        always_ff @(posedge CLK) begin
            if (RST) begin
                Q0 <= '0;
                Q1 <= '0;
            end else begin
                if (rd0) Q0 <= rdata0;
                if (rd1) Q1 <= rdata1;
            end
        end
    end

endmodule
